iob_regfile_2p_drv: RTL

Initiator-side driver for the two-port register file. Converts a CPU-side IOb native byte-addressed request into the packed register-file request word {raddr, waddr, wstrb, wdata} plus write enable, and registers the read response. Multi-byte writes are split into sequential single-byte writes. A clear sequencer zeroes the whole file. Sits between the peripheral CSR decode and the register file instance.

---
 rtl/iob_regfile_2p_drv.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/iob_regfile_2p_drv.sv
// Initiator-side driver for the two-port register file: turns IOb byte requests into
// packed {raddr, waddr, wstrb, wdata} words, splits wide writes into bytes and sequences a clear.
module iob_regfile_2p_drv #(
    parameter  int unsigned N       = 8,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned ADDR_W  = $clog2(N),
    localparam int unsigned WSTRB_W = DATA_W / 8,
    localparam int unsigned WADDR_W = $clog2(N),
    localparam int unsigned RADDR_W = $clog2(N * 8),
    localparam int unsigned REQ_W   = RADDR_W + WADDR_W + WSTRB_W + DATA_W
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               cke_i,
    input  logic               iob_valid_i,
    input  logic [ADDR_W-1:0]  iob_addr_i,
    input  logic [DATA_W-1:0]  iob_wdata_i,
    input  logic [WSTRB_W-1:0] iob_wstrb_i,
    output logic               iob_ready_o,
    output logic               iob_rvalid_o,
    output logic [DATA_W-1:0]  iob_rdata_o,
    input  logic               clear_i,
    output logic               busy_o,
    output logic               wen_o,
    output logic [REQ_W-1:0]   req_o,
    input  logic [DATA_W-1:0]  resp_i
);

    localparam int unsigned LSB_W = $clog2(WSTRB_W);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        CLR
    } state_t;

    state_t               state_q, state_d;
    logic                 init_q, init_d;
    logic [WSTRB_W-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [WADDR_W-1:0]   cnt_q, cnt_d;
    logic [RADDR_W-1:0]   raddr_q, raddr_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [RADDR_W-1:0]   req_raddr;
    logic [WADDR_W-1:0]   req_waddr;
    logic [WSTRB_W-1:0]   req_wstrb;
    logic [DATA_W-1:0]    req_wdata;
    logic                 wen;
    logic                 ready;

    logic [WSTRB_W-1:0]   sel_oh;
    logic [7:0]           sel_byte;
    logic                 sel_ok;
    logic [DATA_W-1:0]    rd_keep;

    // Lowest pending byte of the split write; descending scan leaves the lowest set bit.
    always_comb begin
        sel_oh   = '0;
        sel_byte = '0;
        sel_ok   = 1'b0;
        for (int unsigned b = WSTRB_W; b > 0; b--) begin
            if (|(mask_q & (WSTRB_W'(1) << (b - 1)))) begin
                sel_oh   = WSTRB_W'(1) << (b - 1);
                sel_byte = 8'(wdata_q >> (8 * (b - 1)));
                sel_ok   = (32'(base_q) + b - 1) < N;
            end
        end
    end

    // Byte lanes of a read that fall past the last register are returned as zero.
    always_comb begin
        rd_keep = '0;
        for (int unsigned k = 0; k < WSTRB_W; k++) begin
            if ((32'(iob_addr_i) + k) < N) begin
                rd_keep = rd_keep | (DATA_W'(8'hFF) << (8 * k));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        mask_d    = mask_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        req_raddr = raddr_q;
        req_waddr = '0;
        req_wstrb = '0;
        req_wdata = '0;
        wen       = 1'b0;
        ready     = init_q && cke_i && (state_q == IDLE) && !clear_i;

        if (cke_i) begin
            init_d   = 1'b1;
            rvalid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (init_q) begin
                        if (clear_i) begin
                            state_d = CLR;
                            cnt_d   = '0;
                        end else if (iob_valid_i) begin
                            if (iob_wstrb_i == '0) begin
                                req_raddr = RADDR_W'(iob_addr_i) << 3;
                                raddr_d   = req_raddr;
                                rvalid_d  = 1'b1;
                                rdata_d   = resp_i & rd_keep;
                            end else begin
                                base_d  = iob_addr_i & ~ADDR_W'((1 << LSB_W) - 1);
                                wdata_d = iob_wdata_i;
                                mask_d  = iob_wstrb_i;
                                state_d = WR;
                            end
                        end
                    end
                end
                WR: begin
                    req_waddr = WADDR_W'(base_q);
                    req_wstrb = sel_oh;
                    req_wdata = {WSTRB_W{sel_byte}};
                    wen       = sel_ok;
                    mask_d    = mask_q & ~sel_oh;
                    if ((mask_q & ~sel_oh) == '0) begin
                        state_d = IDLE;
                    end
                end
                CLR: begin
                    req_waddr = cnt_q;
                    req_wstrb = WSTRB_W'(1);
                    wen       = 1'b1;
                    if (cnt_q == WADDR_W'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + WADDR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            init_q   <= 1'b0;
            mask_q   <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            mask_q   <= mask_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign iob_ready_o  = ready;
    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;
    assign busy_o       = (state_q != IDLE);
    assign wen_o        = wen;
    assign req_o        = {req_raddr, req_waddr, req_wstrb, req_wdata};

endmodule
